score_max_tracker: RTL
======================

# score_max_tracker

Sequential running-maximum tracker that sits downstream of the per-cycle max reducer in the alignment datapath. It accepts one candidate (score, row, col) per beat for a fixed number of beats per alignment and keeps the best candidate seen so far. At the end of the alignment it presents the global maximum and its coordinates to the traceback controller on a valid/ready handshake.

## Interface
- NUM_BEATS, 32, number of candidate beats per alignment; must be ≥ 1.
- BEAT_CNT_WIDTH, $clog2(NUM_BEATS+1), width of the internal beat counter; derived, not overridden.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins an alignment; accepted only in IDLE.
- cand_valid  in  1  candidate beat present this cycle.
- cand_score  in  SCORE_WIDTH  candidate score, unsigned.
- cand_row  in  ROW_BITS_WIDTH  candidate row.
- cand_col  in  COL_BITS_WIDTH  candidate column.
- busy  out  1  high in ACCUM and HOLD.
- res_valid  out  1  result available; high only in HOLD.
- res_ready  in  1  consumer accepts the result.
- res_score  out  SCORE_WIDTH  best score.
- res_row  out  ROW_BITS_WIDTH  row of the best score.
- res_col  out  COL_BITS_WIDTH  column of the best score.
- err_protocol  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, ACCUM, HOLD. Reset: IDLE; busy=0, res_valid=0, res_score/row/col=0, err_protocol=0, beat counter=0.
- IDLE + start: go to ACCUM. Clear best to score 0, row 0, col 0; clear the counter; clear err_protocol.
- ACCUM + cand_valid: increment the counter. If cand_score > best_score (strict, unsigned), replace best score/row/col. On ties the earliest beat is kept.
- ACCUM: when the accepted beat brings the counter to NUM_BEATS, go to HOLD. The compare for that beat is included in the result.
- ACCUM + cand_valid low: no change; gaps are unlimited.
- HOLD: res_valid=1; res_* stable. On res_ready=1 go to IDLE; res_* keep their values until the next accepted start.
- res_score/row/col are driven directly from the best registers; they are mid-alignment values while in ACCUM.
- Each of the following sets err_protocol; the offending input is ignored:
  - cand_valid in IDLE or HOLD.
  - start in ACCUM or HOLD.
- start with cand_valid in the same IDLE cycle: start is accepted and the candidate is dropped. err_protocol is set, because set has priority over the start clear.
- If every accepted candidate has score 0, the result is score 0, row 0, col 0.
- rst_n asserted mid-alignment: immediate return to reset values. No partial result is emitted.

## Timing
- Zero-latency acceptance: a beat sampled at edge N is reflected in res_* after edge N.
- The last beat is sampled at edge N. res_valid=1 from edge N to the edge at which res_ready=1 is sampled.
- res_valid drops one cycle after the handshake. The earliest next start is the cycle after the handshake.
- Minimum alignment duration: NUM_BEATS cycles in ACCUM plus 1 cycle in HOLD.
- Critical path: one SCORE_WIDTH comparator plus a 3-field mux into the registers.
- No combinational paths from inputs to outputs.

## Structure
- SCORE_WIDTH, ROW_BITS_WIDTH and COL_BITS_WIDTH come from the shared design_variables package.
- Add the state enum to design_variables as typedef max_trk_state_t {IDLE, ACCUM, HOLD}.
- Single module with no sub-module. The compare/update logic is too small to split out.

## Test plan
- NUM_BEATS=4, start, then beats (5,1,1), (9,2,3), (7,0,4), (2,3,3) -> res_valid after the 4th beat with 9/2/3; res_ready held high -> IDLE next cycle.
- Tie: (6,1,1), (6,2,2), (6,3,3), (6,0,0) -> result 6/1/1 (earliest wins).
- Gaps and backpressure:
  - Beats at cycles 1, 4, 5 and 9, with max (12,3,1) as the last beat -> res_valid after the last beat, result 12/3/1.
  - Hold res_ready=0 for 5 cycles -> res_valid and res_* stay stable for those 5 cycles.
- Violations:
  - cand_valid in IDLE -> err_protocol=1; state and res_* unchanged.
  - start in ACCUM -> err_protocol=1; the counter is not cleared.
  - A subsequent clean start clears err_protocol.
- Assert rst_n after 2 of 4 beats -> IDLE, all outputs 0, no res_valid.
- All-zero beats -> result 0/0/0. SCORE_WIDTH max value as the 2nd beat -> result is the max value with that beat's coordinates.

Source files
------------

// File: rtl/design_variables_pkg.sv
// Shared alignment-datapath widths and the running-max tracker state encoding.
// No logic; constants and types only.
// Imported by every block that carries score/row/col candidates.
package design_variables;

    localparam int SCORE_WIDTH    = 16;
    localparam int ROW_BITS_WIDTH = 10;
    localparam int COL_BITS_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } max_trk_state_t;

endpackage

// File: rtl/score_max_tracker.sv
// Running-maximum tracker: keeps the best (score,row,col) over NUM_BEATS candidate beats.
// Latency: a beat sampled at edge N is visible on res_* after edge N; res_valid rises with the last beat.
// Backpressure: result is held in HOLD until res_ready; candidates/start outside their state are dropped and flagged.
module score_max_tracker
    import design_variables::*;
#(
    parameter int NUM_BEATS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      cand_valid,
    input  logic [SCORE_WIDTH-1:0]    cand_score,
    input  logic [ROW_BITS_WIDTH-1:0] cand_row,
    input  logic [COL_BITS_WIDTH-1:0] cand_col,
    output logic                      busy,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [SCORE_WIDTH-1:0]    res_score,
    output logic [ROW_BITS_WIDTH-1:0] res_row,
    output logic [COL_BITS_WIDTH-1:0] res_col,
    output logic                      err_protocol
);

    localparam int BEAT_CNT_WIDTH = $clog2(NUM_BEATS + 1);
    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(NUM_BEATS - 1);

    max_trk_state_t              state_q, state_d;
    logic [BEAT_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SCORE_WIDTH-1:0]      best_score_q, best_score_d;
    logic [ROW_BITS_WIDTH-1:0]   best_row_q, best_row_d;
    logic [COL_BITS_WIDTH-1:0]   best_col_q, best_col_d;
    logic                        err_q, err_d;

    // Next-state, beat counting, strict-greater compare and sticky protocol flag.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        best_score_d = best_score_q;
        best_row_d   = best_row_q;
        best_col_d   = best_col_q;
        err_d        = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ACCUM;
                    cnt_d        = '0;
                    best_score_d = '0;
                    best_row_d   = '0;
                    best_col_d   = '0;
                    err_d        = 1'b0;
                end
                // A stray candidate is flagged even alongside start: set beats the clear.
                if (cand_valid) begin
                    err_d = 1'b1;
                end
            end
            ACCUM: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (cand_valid) begin
                    cnt_d = cnt_q + BEAT_CNT_WIDTH'(1);
                    // Strict compare keeps the earliest beat on ties.
                    if (cand_score > best_score_q) begin
                        best_score_d = cand_score;
                        best_row_d   = cand_row;
                        best_col_d   = cand_col;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (start || cand_valid) begin
                    err_d = 1'b1;
                end
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to zero/IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            best_score_q <= '0;
            best_row_q   <= '0;
            best_col_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            best_score_q <= best_score_d;
            best_row_q   <= best_row_d;
            best_col_q   <= best_col_d;
            err_q        <= err_d;
        end
    end

    // All outputs come straight from flops: no input-to-output combinational path.
    assign busy         = (state_q != IDLE);
    assign res_valid    = (state_q == HOLD);
    assign res_score    = best_score_q;
    assign res_row      = best_row_q;
    assign res_col      = best_col_q;
    assign err_protocol = err_q;

endmodule
